rfa_wb_arbiter: RTL
===================

RFA_WB_ARBITER -- requirements
Module: rfa_wb_arbiter

Interface
REQ-001 Parameter NUM_ALU SHALL default to 4 and set the number of ALU writeback requesters.
REQ-002 Parameter LSU_STREAK_MAX SHALL default to 8 and set the maximum consecutive LSU grants allowed while an ALU is eligible.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port alu_queue_entry_valid  input  NUM_ALU  SHALL carry one bit per ALU, set while that ALU holds a pending writeback queue entry.
REQ-006 Port lsu_wr_req  input  1  SHALL be the LSU request for the shared register-file write slot.
REQ-007 Port alu_queue_entry_serviced  output  NUM_ALU  SHALL be a one-hot (or zero) one-cycle pulse granting the slot to one ALU.
REQ-008 Port lsu_wr_grant  output  1  SHALL be a one-cycle pulse granting the slot to the LSU.
REQ-009 Port arb_busy  output  1  SHALL be high in any cycle in which a grant output is high.

Function
REQ-010 All outputs SHALL be registered; a request sampled at edge t SHALL produce its grant in the cycle after edge t (latency 1).
REQ-011 At most one bit across alu_queue_entry_serviced and lsu_wr_grant SHALL be high in any cycle.
REQ-012 An ALU is eligible when its valid bit is high and it was not granted in the immediately preceding cycle (last-grant mask), preventing a double grant against a not-yet-dropped valid.
REQ-013 Priority SHALL be: LSU when lsu_wr_req is high and streak_cnt < LSU_STREAK_MAX; otherwise an eligible ALU by round-robin; otherwise the LSU if requesting; otherwise no grant.
REQ-014 Round-robin SHALL search from rr_ptr upward, wrapping from NUM_ALU-1 to 0; after an ALU k grant, rr_ptr SHALL become (k+1) mod NUM_ALU; rr_ptr SHALL be unchanged on LSU grants or idle cycles.
REQ-015 streak_cnt SHALL increment (saturating at LSU_STREAK_MAX) on each LSU grant made while any ALU is eligible, and SHALL clear to 0 on any ALU grant or in any cycle with no eligible ALU.
REQ-016 When streak_cnt = LSU_STREAK_MAX and an ALU is eligible, the ALU SHALL win even with lsu_wr_req high; the LSU SHALL be granted in a later cycle.
REQ-017 The last-grant mask SHALL hold only the ALU granted in the previous cycle and SHALL clear after one cycle with no ALU grant.
REQ-018 Requesters dropping valid in the same cycle they would be selected SHALL NOT be granted (selection uses sampled inputs only).
REQ-019 With a single ALU continuously valid and no LSU, grants SHALL occur every other cycle.

Reset
REQ-020 While rst is high, all outputs SHALL be 0 in the following cycle, rr_ptr SHALL be 0, streak_cnt SHALL be 0, and the last-grant mask SHALL be cleared.
REQ-021 Requests sampled while rst is high SHALL be ignored; assertion of rst mid-sequence SHALL discard pending arbitration state without emitting a grant.

Structure
REQ-022 The default values of NUM_ALU and LSU_STREAK_MAX, plus the streak-counter width constant, SHALL live in the shared ALU definitions package/header.
REQ-023 The rotating priority pick SHALL be one combinational sub-module, rfa_rr_pick (inputs: eligible vector, rr_ptr; outputs: found, one-hot pick).

Verification
REQ-024 Reset, then alu valid=4'b1111 held, no LSU -> serviced sequence 0001, 0010, 0100, 1000, 0001, with no ALU granted twice in consecutive cycles.
REQ-025 lsu_wr_req=1 and alu valid=4'b0100 held -> 8 lsu_wr_grant pulses, then serviced=0100, then LSU grants resume with streak_cnt restarting at 0.
REQ-026 Only alu valid=4'b0001 held -> serviced toggles 0001, 0000, 0001, 0000; arb_busy matches.
REQ-027 rr_ptr=3 with valid=4'b1001 -> serviced=1000, then next eligible pick 0001 (wrap-around).
REQ-028 rst asserted for one cycle amid traffic -> all outputs 0 the following cycle, then first grant goes to ALU 0 when valid=4'b1111.
REQ-029 Random valid/lsu stimulus, 10k cycles -> at most one grant per cycle, no ALU starved beyond NUM_ALU*(LSU_STREAK_MAX+2) cycles.

Source files
------------

// File: rtl/rfa_wb_pkg.sv
// Shared ALU writeback definitions: requester defaults, streak counter width
// and the grant-kind encoding used by the writeback arbiter.
package rfa_wb_pkg;

  localparam int NUM_ALU_DEFAULT        = 4;
  localparam int LSU_STREAK_MAX_DEFAULT = 8;
  localparam int STREAK_W               = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LSU  = 2'd1,
    GNT_ALU  = 2'd2
  } gnt_kind_e;

  // Counter width able to hold max_v, never narrower than the shared default.
  function automatic int streak_width(input int max_v);
    int need;
    need = $clog2(max_v + 1);
    return (need > STREAK_W) ? need : STREAK_W;
  endfunction

endpackage

// File: rtl/rfa_wb_arbiter_rr_pick.sv
// Rotating-priority pick: first eligible requester at or above rr_ptr,
// wrapping from the top index back to 0. Purely combinational.
module rfa_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] rr_ptr,
  output logic          found,
  output logic [N-1:0]  pick
);

  // Walk the requesters in rotated order and keep the first eligible one.
  always_comb begin
    found = 1'b0;
    pick  = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % N;
      if (!found && eligible[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/rfa_wb_arbiter.sv
// Register-file writeback slot arbiter between NUM_ALU ALU queues and the LSU.
// LSU has priority until it has taken LSU_STREAK_MAX slots in a row while an
// ALU was waiting; ALUs share by round-robin. All grants are registered pulses.
module rfa_wb_arbiter
  import rfa_wb_pkg::*;
#(
  parameter int NUM_ALU        = NUM_ALU_DEFAULT,
  parameter int LSU_STREAK_MAX = LSU_STREAK_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_ALU-1:0] alu_queue_entry_valid,
  input  logic               lsu_wr_req,
  output logic [NUM_ALU-1:0] alu_queue_entry_serviced,
  output logic               lsu_wr_grant,
  output logic               arb_busy
);

  localparam int PW = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
  localparam int SW = streak_width(LSU_STREAK_MAX);
  localparam logic [SW-1:0] STREAK_MAX_C = SW'(LSU_STREAK_MAX);

  logic [PW-1:0]      rr_ptr_r;
  logic [SW-1:0]      streak_r;
  logic [NUM_ALU-1:0] svc_r;      // doubles as the last-grant mask
  logic               lsu_gnt_r;
  logic               busy_r;

  logic [NUM_ALU-1:0] eligible_s;
  logic               any_elig_s;
  logic               found_s;
  logic [NUM_ALU-1:0] pick_s;
  gnt_kind_e          kind_s;

  logic [NUM_ALU-1:0] svc_nxt_s;
  logic               lsu_nxt_s;
  logic [SW-1:0]      streak_nxt_s;
  logic [PW-1:0]      ptr_nxt_s;

  // An ALU granted last cycle may still show valid; mask it for one cycle.
  assign eligible_s = alu_queue_entry_valid & ~svc_r;
  assign any_elig_s = |eligible_s;

  rfa_rr_pick #(
    .N  (NUM_ALU),
    .PW (PW)
  ) u_pick (
    .eligible (eligible_s),
    .rr_ptr   (rr_ptr_r),
    .found    (found_s),
    .pick     (pick_s)
  );

  // Priority decision: LSU under streak limit, then ALU round-robin, then LSU.
  always_comb begin
    kind_s = GNT_NONE;
    if (lsu_wr_req && (streak_r < STREAK_MAX_C)) begin
      kind_s = GNT_LSU;
    end else if (found_s) begin
      kind_s = GNT_ALU;
    end else if (lsu_wr_req) begin
      kind_s = GNT_LSU;
    end else begin
      kind_s = GNT_NONE;
    end
  end

  // Next grant outputs and streak count for the chosen grant kind.
  always_comb begin
    svc_nxt_s    = {NUM_ALU{1'b0}};
    lsu_nxt_s    = 1'b0;
    streak_nxt_s = streak_r;
    case (kind_s)
      GNT_LSU: begin
        lsu_nxt_s = 1'b1;
        if (!any_elig_s) begin
          streak_nxt_s = {SW{1'b0}};
        end else if (streak_r >= STREAK_MAX_C) begin
          streak_nxt_s = STREAK_MAX_C;
        end else begin
          streak_nxt_s = streak_r + {{(SW-1){1'b0}}, 1'b1};
        end
      end
      GNT_ALU: begin
        svc_nxt_s    = pick_s;
        streak_nxt_s = {SW{1'b0}};
      end
      default: begin
        // Idle only happens with no eligible ALU, which clears the streak.
        streak_nxt_s = {SW{1'b0}};
      end
    endcase
  end

  // Round-robin pointer moves just past the ALU that wins the slot.
  always_comb begin
    ptr_nxt_s = rr_ptr_r;
    for (int i = 0; i < NUM_ALU; i++) begin
      if ((kind_s == GNT_ALU) && pick_s[i]) begin
        ptr_nxt_s = PW'((i + 1) % NUM_ALU);
      end else begin
        ptr_nxt_s = ptr_nxt_s;
      end
    end
  end

  // Arbitration state and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r  <= {PW{1'b0}};
      streak_r  <= {SW{1'b0}};
      svc_r     <= {NUM_ALU{1'b0}};
      lsu_gnt_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      rr_ptr_r  <= ptr_nxt_s;
      streak_r  <= streak_nxt_s;
      svc_r     <= svc_nxt_s;
      lsu_gnt_r <= lsu_nxt_s;
      busy_r    <= lsu_nxt_s | (|svc_nxt_s);
    end
  end

  assign alu_queue_entry_serviced = svc_r;
  assign lsu_wr_grant             = lsu_gnt_r;
  assign arb_busy                 = busy_r;

endmodule
